ks_array4_pipe: RTL



---
 rtl/ks_array4_pipe.sv | 85 ++++++++
 1 files changed

// File: rtl/ks_array4_pipe.sv
// ks_array4_pipe: span-16 Kogge-Stone combine, sum/carry forming and a valid/ready skid buffer.
// Define KS_OVF_EN to add the signed-overflow output and its storage bit.
module ks_array4_pipe #(
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_Gk,
  input  logic [WIDTH-1:WIDTH/2]   in_Pk,
  input  logic [WIDTH-1:0]         in_Hk,
  input  logic                     in_cin,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_sum,
  output logic                     out_cout
`ifdef KS_OVF_EN
  ,
  output logic                     out_ovf
`endif
);
  if (WIDTH != 16) begin : g_bad_width
    $error("ks_array4_pipe: WIDTH must be 16");
  end
  localparam int H = WIDTH / 2;
`ifdef KS_OVF_EN
  localparam int DW = WIDTH + 2;
`else
  localparam int DW = WIDTH + 1;
`endif
  // State bits chosen so in_ready and out_valid come straight from flops.
  typedef enum logic [1:0] {EMPTY = 2'b00, ONE = 2'b01, FULL = 2'b11} state_t;
  state_t state, nxt;
  logic [WIDTH-1:0] c, sum;
  logic [DW-1:0] new_d, m_d, s_d;
  logic accept, consume, ld_m, m_from_s, ld_s;
  assign c = {in_Gk[WIDTH-1:H] | (in_Pk & in_Gk[H-1:0]), in_Gk[H-1:0]};
  assign sum = in_Hk ^ {c[WIDTH-2:0], in_cin};
`ifdef KS_OVF_EN
  assign new_d = {c[WIDTH-2] ^ c[WIDTH-1], c[WIDTH-1], sum};
  assign out_ovf = m_d[WIDTH+1];
`else
  assign new_d = {c[WIDTH-1], sum};
`endif
  assign in_ready = ~state[1];
  assign out_valid = state[0];
  assign {out_cout, out_sum} = m_d[WIDTH:0];
  assign accept = in_valid & in_ready;
  assign consume = out_valid & out_ready;
  always_comb begin
    nxt = state;
    ld_m = 1'b0;
    m_from_s = 1'b0;
    ld_s = 1'b0;
    case (state)
      EMPTY: begin
        ld_m = accept;
        nxt = accept ? ONE : EMPTY;
      end
      ONE: begin
        ld_m = accept & consume;
        ld_s = accept & ~consume;
        nxt = (accept & ~consume) ? FULL : (consume & ~accept) ? EMPTY : ONE;
      end
      FULL: begin
        ld_m = consume;
        m_from_s = 1'b1;
        nxt = consume ? ONE : FULL;
      end
      default: nxt = EMPTY;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      m_d <= '0;
      s_d <= '0;
    end else begin
      state <= nxt;
      if (ld_m) m_d <= m_from_s ? s_d : new_d;
      if (ld_s) s_d <= new_d;
    end
  end
endmodule
